lsu_mem_if: RTL and testbench
=============================

Name: lsu_mem_if

Overview:
Load/store initiator for the rv32i data path. It converts a core-side load/store request (funct3 size/sign, byte address, store data) into word-aligned memory transactions with byte enables. It sign- or zero-extends load data on return and splits misaligned accesses into two word beats. It sits between the execute stage and the data memory, acting as the requesting end of the data-memory port.

Parameters:
SPLIT_MISALIGNED, 1, 1: misaligned accesses are split into two beats; 0: misaligned accesses raise err_o with no memory access.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  core request; accepted when req_i && ready_o
we_i  in  1  1 = store, 0 = load
funct3_i  in  3  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU (stores use 0/1/2)
addr_i  in  32  byte address (word_ut)
wdata_i  in  32  store data (word_st)
ready_o  out  1  high only in IDLE
done_o  out  1  1-cycle pulse at completion
err_o  out  1  1-cycle pulse on illegal funct3, or on misalignment when SPLIT_MISALIGNED=0
rdata_o  out  32  extended load data, valid with done_o; 0 for stores
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory accepted the request this cycle
mem_we_o  out  1  write enable
mem_addr_o  out  32  word-aligned address, bits[1:0]=0
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-aligned store data
mem_rvalid_i  in  1  response/ack; one per granted beat, loads and stores alike
mem_rdata_i  in  32  read word, valid with mem_rvalid_i

Behaviour:
- Reset (async, rst_ni=0): FSM to IDLE. All outputs 0 except ready_o=1. Captured registers cleared. An in-flight transaction is abandoned and a later stray rvalid is ignored.
- On accept in IDLE, register we, funct3, addr, and wdata. The core may change inputs afterwards.
- Size: funct3[1:0] gives 0→1 byte, 1→2 bytes, 2→4 bytes. off = addr[1:0].
- Legal funct3 is {0,1,2,4,5} for loads and {0,1,2} for stores. Any other value: err_o pulses the cycle after accept, back to IDLE, no mem_req_o.
- Misaligned means a halfword with off=3, or a word with off≠0. Two beats are needed.
- 8-bit mask = size_mask << off. Beat0 uses be = mask[3:0]. Beat1 uses be = mask[7:4].
- 64-bit store data = zero-extended wdata << 8*off. Beat0 takes bits [31:0], beat1 takes bits [63:32].
- Beat0 address = {addr[31:2],2'b00}. Beat1 address = beat0 + 4 mod 2^32; 0xFFFFFFFC wraps to 0x00000000.
- FSM states: IDLE → REQ0 → WAIT0 → (REQ1 → WAIT1 if split) → IDLE.
  - REQx: mem_req_o=1 with address, be, we, and wdata held stable until mem_gnt_i. On gnt, go to WAITx; mem_req_o drops the next cycle.
  - WAITx: on mem_rvalid_i, capture mem_rdata_i into beat register x.
  - gnt and rvalid in the same cycle can never be for the same beat, because rvalid arrives ≥1 cycle after gnt.
- Completion: the cycle after the final rvalid, done_o=1 and FSM=IDLE (ready_o=1 in that same cycle).
- Load result: rdata_o = ({beat1,beat0} >> 8*off) truncated to size, then sign-extended (funct3 0/1) or zero-extended (4/5).
- Latency: an aligned access with gnt on the first REQ cycle and rvalid 1 cycle later gives accept at T, req at T+1, rvalid at T+2, done_o at T+3.
- mem_rvalid_i outside WAITx is ignored. Only one transaction is outstanding at a time.
- req_i while ready_o=0 is ignored (not queued).

Decomposition:
- definitions_pkg gains:
  - lsu_funct3_e enum (LB, LH, LW, LBU, LHU)
  - lsu_state_e enum
  - a constant-function helper for the size mask
- The package reuses word_ut/word_st.
- One sub-module, lsu_align, is purely combinational. It computes be, shifted store data, the misaligned flag, and load extraction/extension.

Test Plan:
- LW addr 0x100, mem returns 0xDEADBEEF (gnt immediate, rvalid +1) → one beat at mem_addr 0x100, be=1111, done_o at T+3, rdata_o=0xDEADBEEF.
- LB addr 0x103, word 0x80123456 → be=1000, rdata_o=0xFFFFFF80. Same word with LBU → 0x00000080.
- SH addr 0x102, wdata 0x0000ABCD → be=1100, mem_wdata_o=0xABCD0000, mem_we_o=1, done_o with rdata_o=0.
- LW addr 0x1FE, words 0x11223344 @0x1FC and 0x55667788 @0x200 → two beats with be=1100 then 0011, rdata_o=0x77881122. Repeat with SPLIT_MISALIGNED=0 → err_o pulse, no mem_req_o.
- SW addr 0xFFFFFFFF, wdata 0xAABBCCDD → beat0 0xFFFFFFFC be=1000 wdata=0xDD000000, beat1 0x00000000 be=0111 wdata=0x00AABBCC. Hold gnt low 3 cycles → request held stable.
- funct3=3 load → err_o only. Then assert rst_ni=0 during WAIT0 and deliver rvalid after release → FSM in IDLE, no done_o, ready_o=1.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared rv32i data-path types and load/store helpers.
// Used by the LSU memory initiator and its alignment datapath.
package definitions_pkg;

    typedef logic [31:0]        word_ut;
    typedef logic signed [31:0] word_st;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } lsu_funct3_e;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_REQ0,
        LSU_WAIT0,
        LSU_REQ1,
        LSU_WAIT1
    } lsu_state_e;

    function automatic logic [3:0] lsu_size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] off);
        return ((size == 2'd1) && (off == 2'd3)) ||
               ((size == 2'd2) && (off != 2'd0));
    endfunction

    function automatic logic lsu_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            LB, LH, LW: ok = 1'b1;
            LBU, LHU:   ok = !we;
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_mem_if_align.sv
// Combinational lane alignment: byte enables, store data shift,
// misalignment detection and load extraction/extension.
module lsu_align
    import definitions_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [1:0] off_i,
    input  word_ut     wdata_i,
    input  word_ut     beat0_i,
    input  word_ut     beat1_i,
    output logic [3:0] be0_o,
    output logic [3:0] be1_o,
    output word_ut     wdata0_o,
    output word_ut     wdata1_o,
    output logic       misaligned_o,
    output word_ut     rdata_o
);

    logic [1:0]  w_size;
    logic [4:0]  w_sh;
    logic [7:0]  w_mask;
    logic [63:0] w_wide;
    word_ut      w_lo;

    assign w_size = funct3_i[1:0];
    assign w_sh   = {off_i, 3'b000};
    assign w_mask = {4'b0000, lsu_size_mask(w_size)} << off_i;
    assign w_wide = {32'd0, wdata_i} << w_sh;

    assign be0_o        = w_mask[3:0];
    assign be1_o        = w_mask[7:4];
    assign wdata0_o     = w_wide[31:0];
    assign wdata1_o     = w_wide[63:32];
    assign misaligned_o = lsu_misaligned(w_size, off_i);

    // Low word of {beat1,beat0} >> 8*off; a shift by 32 yields zero.
    assign w_lo = (beat0_i >> w_sh) | (beat1_i << (6'd32 - {1'b0, w_sh}));

    always_comb begin
        rdata_o = w_lo;
        case (w_size)
            2'd0: rdata_o = funct3_i[2] ? {24'd0, w_lo[7:0]}
                                        : {{24{w_lo[7]}}, w_lo[7:0]};
            2'd1: rdata_o = funct3_i[2] ? {16'd0, w_lo[15:0]}
                                        : {{16{w_lo[15]}}, w_lo[15:0]};
            default: rdata_o = w_lo;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store initiator: turns core requests into word-aligned
// memory beats, splitting misaligned accesses into two.
module lsu_mem_if
    import definitions_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
)
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  word_ut      addr_i,
    input  word_ut      wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output word_ut      rdata_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic        mem_we_o,
    output word_ut      mem_addr_o,
    output logic [3:0]  mem_be_o,
    output word_ut      mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  word_ut      mem_rdata_i
);

    lsu_state_e r_state;
    lsu_state_e w_state_nxt;

    logic       r_we;
    logic [2:0] r_funct3;
    word_ut     r_addr;
    word_ut     r_wdata;
    word_ut     r_beat0;
    word_ut     r_beat1;
    word_ut     r_rdata;
    logic       r_done;
    logic       r_err;

    logic       w_accept;
    logic       w_bad;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic       w_split;
    word_ut     w_beat0;
    word_ut     w_beat1;
    word_ut     w_ld_data;
    word_ut     w_wdata0;
    word_ut     w_wdata1;
    logic [3:0] w_be0;
    logic [3:0] w_be1;

    assign w_accept = req_i && (r_state == LSU_IDLE);
    assign w_bad    = !lsu_legal(we_i, funct3_i) ||
                      (!SPLIT_MISALIGNED &&
                       lsu_misaligned(funct3_i[1:0], addr_i[1:0]));

    // Forward the returning word so the result is ready on the final rvalid.
    assign w_beat0 = (r_state == LSU_WAIT0) ? mem_rdata_i : r_beat0;
    assign w_beat1 = (r_state == LSU_WAIT1) ? mem_rdata_i : r_beat1;

    lsu_align u_align (
        .funct3_i     (r_funct3),
        .off_i        (r_addr[1:0]),
        .wdata_i      (r_wdata),
        .beat0_i      (w_beat0),
        .beat1_i      (w_beat1),
        .be0_o        (w_be0),
        .be1_o        (w_be1),
        .wdata0_o     (w_wdata0),
        .wdata1_o     (w_wdata1),
        .misaligned_o (w_split),
        .rdata_o      (w_ld_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (req_i) begin
                    if (w_bad) w_err_nxt   = 1'b1;
                    else       w_state_nxt = LSU_REQ0;
                end
            end
            LSU_REQ0: if (mem_gnt_i) w_state_nxt = LSU_WAIT0;
            LSU_WAIT0: begin
                if (mem_rvalid_i) begin
                    if (w_split) begin
                        w_state_nxt = LSU_REQ1;
                    end else begin
                        w_state_nxt = LSU_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            LSU_REQ1: if (mem_gnt_i) w_state_nxt = LSU_WAIT1;
            LSU_WAIT1: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = LSU_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= LSU_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_beat0  <= '0;
            r_beat1  <= '0;
            r_rdata  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= (w_done_nxt && !r_we) ? w_ld_data : '0;
            if (w_accept) begin
                r_we     <= we_i;
                r_funct3 <= funct3_i;
                r_addr   <= addr_i;
                r_wdata  <= wdata_i;
            end
            if ((r_state == LSU_WAIT0) && mem_rvalid_i) r_beat0 <= mem_rdata_i;
            if ((r_state == LSU_WAIT1) && mem_rvalid_i) r_beat1 <= mem_rdata_i;
        end
    end

    assign ready_o = (r_state == LSU_IDLE);
    assign done_o  = r_done;
    assign err_o   = r_err;
    assign rdata_o = r_rdata;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'd0;
        mem_wdata_o = '0;
        case (r_state)
            LSU_REQ0: begin
                mem_req_o   = 1'b1;
                mem_we_o    = r_we;
                mem_addr_o  = {r_addr[31:2], 2'b00};
                mem_be_o    = w_be0;
                mem_wdata_o = w_wdata0;
            end
            LSU_REQ1: begin
                mem_req_o   = 1'b1;
                mem_we_o    = r_we;
                mem_addr_o  = {r_addr[31:2] + 30'd1, 2'b00};
                mem_be_o    = w_be1;
                mem_wdata_o = w_wdata1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: vector table plus reset and
// no-split corner sequences.
module tb_lsu_mem_if;
    import definitions_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        ready_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    logic        z_req = 1'b0;
    logic        z_ready, z_done, z_err;
    logic [31:0] z_rdata;
    logic        z_mreq, z_mwe;
    logic [31:0] z_maddr, z_mwdata;
    logic [3:0]  z_mbe;
    logic        z_gnt = 1'b0;
    logic        z_rvalid = 1'b0;
    logic [31:0] z_mrdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_mem_if #(.SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
        .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    lsu_mem_if #(.SPLIT_MISALIGNED(1'b0)) u_dut_nosplit (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(z_req), .we_i(we_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ready_o(z_ready), .done_o(z_done), .err_o(z_err),
        .rdata_o(z_rdata), .mem_req_o(z_mreq), .mem_gnt_i(z_gnt),
        .mem_we_o(z_mwe), .mem_addr_o(z_maddr), .mem_be_o(z_mbe),
        .mem_wdata_o(z_mwdata), .mem_rvalid_i(z_rvalid),
        .mem_rdata_i(z_mrdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] d0;
        logic [31:0] d1;
        int          gw;
        logic        err;
        logic        split;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        logic [31:0] ea;
        logic [3:0]  eb;
        logic [31:0] ew;
        int nb;
        p = $sformatf("v%0d", idx);
        chk({p, ".ready"}, 32'(ready_o), 32'd1);
        req_i = 1'b1;
        we_i = v.we;
        funct3_i = v.f3;
        addr_i = v.addr;
        wdata_i = v.wdata;
        tick();
        req_i = 1'b0;
        we_i = ~v.we;
        funct3_i = 3'd7;
        addr_i = 32'h5A5A5A5A;
        wdata_i = 32'hA5A5A5A5;
        if (v.err) begin
            chk({p, ".err"}, 32'(err_o), 32'd1);
            chk({p, ".noreq"}, 32'(mem_req_o), 32'd0);
            chk({p, ".ready_err"}, 32'(ready_o), 32'd1);
            tick();
            chk({p, ".err_end"}, 32'(err_o), 32'd0);
            chk({p, ".noreq2"}, 32'(mem_req_o), 32'd0);
            return;
        end
        chk({p, ".noerr"}, 32'(err_o), 32'd0);
        nb = v.split ? 2 : 1;
        for (int b = 0; b < nb; b++) begin
            ea = (b == 0) ? v.a0 : v.a1;
            eb = (b == 0) ? v.be0 : v.be1;
            ew = (b == 0) ? v.wd0 : v.wd1;
            for (int w = 0; w <= v.gw; w++) begin
                chk($sformatf("%s.b%0d.req", p, b), 32'(mem_req_o), 32'd1);
                chk($sformatf("%s.b%0d.addr", p, b), mem_addr_o, ea);
                chk($sformatf("%s.b%0d.be", p, b), 32'(mem_be_o), 32'(eb));
                chk($sformatf("%s.b%0d.we", p, b), 32'(mem_we_o), 32'(v.we));
                chk($sformatf("%s.b%0d.wdata", p, b), mem_wdata_o, ew);
                chk($sformatf("%s.b%0d.busy", p, b), 32'(ready_o), 32'd0);
                if (w == v.gw) mem_gnt_i = 1'b1;
                tick();
            end
            mem_gnt_i = 1'b0;
            chk($sformatf("%s.b%0d.reqdrop", p, b), 32'(mem_req_o), 32'd0);
            chk($sformatf("%s.b%0d.nodone", p, b), 32'(done_o), 32'd0);
            mem_rvalid_i = 1'b1;
            mem_rdata_i = (b == 0) ? v.d0 : v.d1;
            tick();
            mem_rvalid_i = 1'b0;
            mem_rdata_i = 32'hCAFEF00D;
        end
        chk({p, ".done"}, 32'(done_o), 32'd1);
        chk({p, ".rdata"}, rdata_o, v.rd);
        chk({p, ".ready_done"}, 32'(ready_o), 32'd1);
        tick();
        chk({p, ".done_end"}, 32'(done_o), 32'd0);
        chk({p, ".idle_req"}, 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        //           we f3    addr          wdata         d0            d1            gw err sp a0            be0      wd0           a1            be1      wd1           rd
        vecs[0]  = '{0, 3'd2, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h00000100, 4'b1111, 32'h00000000, 32'h0,        4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{0, 3'd0, 32'h00000103, 32'h00000000, 32'h80123456, 32'h0,        0, 0, 0, 32'h00000100, 4'b1000, 32'h00000000, 32'h0,        4'b0000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{0, 3'd4, 32'h00000103, 32'h00000000, 32'h80123456, 32'h0,        0, 0, 0, 32'h00000100, 4'b1000, 32'h00000000, 32'h0,        4'b0000, 32'h0,        32'h00000080};
        vecs[3]  = '{1, 3'd1, 32'h00000102, 32'h0000ABCD, 32'h12345678, 32'h0,        1, 0, 0, 32'h00000100, 4'b1100, 32'hABCD0000, 32'h0,        4'b0000, 32'h0,        32'h00000000};
        vecs[4]  = '{0, 3'd2, 32'h000001FE, 32'h00000000, 32'h11223344, 32'h55667788, 0, 0, 1, 32'h000001FC, 4'b1100, 32'h00000000, 32'h00000200, 4'b0011, 32'h00000000, 32'h77881122};
        vecs[5]  = '{1, 3'd2, 32'hFFFFFFFF, 32'hAABBCCDD, 32'h0,        32'h0,        3, 0, 1, 32'hFFFFFFFC, 4'b1000, 32'hDD000000, 32'h00000000, 4'b0111, 32'h00AABBCC, 32'h00000000};
        vecs[6]  = '{0, 3'd1, 32'h00000101, 32'h00000000, 32'h12ABCD34, 32'h0,        0, 0, 0, 32'h00000100, 4'b0110, 32'h00000000, 32'h0,        4'b0000, 32'h0,        32'hFFFFABCD};
        vecs[7]  = '{0, 3'd5, 32'h00000101, 32'h00000000, 32'h12ABCD34, 32'h0,        2, 0, 0, 32'h00000100, 4'b0110, 32'h00000000, 32'h0,        4'b0000, 32'h0,        32'h0000ABCD};
        vecs[8]  = '{0, 3'd1, 32'h00000203, 32'h00000000, 32'hAB000000, 32'h000000CD, 0, 0, 1, 32'h00000200, 4'b1000, 32'h00000000, 32'h00000204, 4'b0001, 32'h00000000, 32'hFFFFCDAB};
        vecs[9]  = '{1, 3'd0, 32'h00000041, 32'h123456EE, 32'h0,        32'h0,        0, 0, 0, 32'h00000040, 4'b0010, 32'h3456EE00, 32'h0,        4'b0000, 32'h0,        32'h00000000};
        vecs[10] = '{0, 3'd3, 32'h00000100, 32'h00000000, 32'h0,        32'h0,        0, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1, 3'd4, 32'h00000100, 32'h00000011, 32'h0,        32'h0,        0, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[12] = '{0, 3'd6, 32'h00000102, 32'h00000000, 32'h0,        32'h0,        0, 1, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[13] = '{0, 3'd5, 32'h00000102, 32'h00000000, 32'hBEEF1234, 32'h0,        1, 0, 0, 32'h00000100, 4'b1100, 32'h00000000, 32'h0,        4'b0000, 32'h0,        32'h0000BEEF};
        vecs[14] = '{1, 3'd2, 32'h00000010, 32'h01020304, 32'h0,        32'h0,        0, 0, 0, 32'h00000010, 4'b1111, 32'h01020304, 32'h0,        4'b0000, 32'h0,        32'h00000000};

        tick();
        tick();
        chk("rst.ready", 32'(ready_o), 32'd1);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.err", 32'(err_o), 32'd0);
        chk("rst.rdata", rdata_o, 32'd0);
        chk("rst.mem_req", 32'(mem_req_o), 32'd0);
        chk("rst.mem_addr", mem_addr_o, 32'd0);
        chk("rst.mem_be", 32'(mem_be_o), 32'd0);
        chk("rst.mem_we", 32'(mem_we_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while waiting for the response; late rvalid must be dropped.
        req_i = 1'b1;
        we_i = 1'b0;
        funct3_i = 3'd2;
        addr_i = 32'h00000100;
        tick();
        req_i = 1'b0;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk("mrst.wait_busy", 32'(ready_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("mrst.async_ready", 32'(ready_o), 32'd1);
        tick();
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h13579BDF;
        tick();
        mem_rvalid_i = 1'b0;
        chk("mrst.no_done", 32'(done_o), 32'd0);
        chk("mrst.ready", 32'(ready_o), 32'd1);
        chk("mrst.rdata", rdata_o, 32'd0);
        tick();
        chk("mrst.no_done2", 32'(done_o), 32'd0);
        chk("mrst.no_req", 32'(mem_req_o), 32'd0);

        // Busy DUT ignores req_i: after accept a second request is not queued.
        req_i = 1'b1;
        addr_i = 32'h00000200;
        tick();
        chk("busy.req0", 32'(mem_req_o), 32'd1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        req_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h00C0FFEE;
        tick();
        mem_rvalid_i = 1'b0;
        chk("busy.done", 32'(done_o), 32'd1);
        chk("busy.rdata", rdata_o, 32'h00C0FFEE);
        tick();
        chk("busy.no_second", 32'(mem_req_o), 32'd0);

        // Non-splitting instance: misaligned word raises err only.
        we_i = 1'b0;
        funct3_i = 3'd2;
        addr_i = 32'h000001FE;
        z_req = 1'b1;
        tick();
        z_req = 1'b0;
        chk("nosplit.err", 32'(z_err), 32'd1);
        chk("nosplit.noreq", 32'(z_mreq), 32'd0);
        chk("nosplit.ready", 32'(z_ready), 32'd1);
        tick();
        chk("nosplit.err_end", 32'(z_err), 32'd0);
        chk("nosplit.noreq2", 32'(z_mreq), 32'd0);
        addr_i = 32'h00000100;
        z_req = 1'b1;
        tick();
        z_req = 1'b0;
        chk("nosplit.al_req", 32'(z_mreq), 32'd1);
        chk("nosplit.al_addr", z_maddr, 32'h00000100);
        chk("nosplit.al_be", 32'(z_mbe), 32'hF);
        z_gnt = 1'b1;
        tick();
        z_gnt = 1'b0;
        z_rvalid = 1'b1;
        z_mrdata = 32'h0BADF00D;
        tick();
        z_rvalid = 1'b0;
        chk("nosplit.al_done", 32'(z_done), 32'd1);
        chk("nosplit.al_rdata", z_rdata, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
